// File: rtl/ulpi_pkg.sv
// Shared types and encodings for the ULPI link-side controller.
package ulpi_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 6;

  // Link TX CMD prefix for an immediate register write
  localparam logic [1:0] TXCMD_REGWR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN_IN,
    ST_RX,
    ST_TURN_OUT,
    ST_TX_CMD,
    ST_TX_DATA,
    ST_TX_STP
  } ulpi_state_e;

  // RX CMD byte layout; rxevent[0] is the RxActive flag
  typedef struct packed {
    logic [1:0] misc;
    logic [1:0] rxevent;
    logic [1:0] vbus;
    logic [1:0] linestate;
  } rx_cmd_t;

  function automatic logic [DATA_W-1:0] regwr_cmd(input logic [ADDR_W-1:0] addr);
    return {TXCMD_REGWR, addr};
  endfunction

endpackage

// File: rtl/ulpi_link.sv
// ULPI link-side controller: RX CMD/data decode and PHY register writes.
// Optional ULPI_RXCMD_FILTER_EN: only pulse rx_cmd_valid when the RX CMD changes.
module ulpi_link
  import ulpi_pkg::*;
#(
  parameter int unsigned NXT_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk_ulpi,
  input  logic              rst,
  input  logic              ulpi_dir,
  input  logic              ulpi_nxt,
  output logic              ulpi_stp,
  input  logic [DATA_W-1:0] ulpi_data_in,
  output logic [DATA_W-1:0] ulpi_data_out,
  output logic              ulpi_data_oe,
  input  logic              reg_wr_req,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic              reg_busy,
  output logic              reg_done,
  output logic              reg_err,
  output logic              rx_cmd_valid,
  output logic [DATA_W-1:0] rx_cmd,
  output logic              rx_data_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_active,
  output logic              rx_end
);

  ulpi_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stp_q, stp_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cmd_valid_q, cmd_valid_d;
  rx_cmd_t           rx_cmd_q, rx_cmd_d;
  logic              data_valid_q, data_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_active_q, rx_active_d;
  logic              rx_end_q, rx_end_d;
  logic              accept;
  logic              timeout;
`ifdef ULPI_RXCMD_FILTER_EN
  logic              cmd_seen_q, cmd_seen_d;
`endif

  assign timeout = (cnt_q == CNT_W'(NXT_TIMEOUT - 1));

  // Next state, bookkeeping and the lookahead values of the registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cmd_valid_d  = 1'b0;
    rx_cmd_d     = rx_cmd_q;
    data_valid_d = 1'b0;
    rx_data_d    = rx_data_q;
    rx_active_d  = rx_active_q;
    rx_end_d     = 1'b0;
    accept       = 1'b0;
`ifdef ULPI_RXCMD_FILTER_EN
    cmd_seen_d   = cmd_seen_q;
`endif

    case (state_q)
      ST_IDLE: begin
        accept = reg_wr_req & ~busy_q;
        if (accept) begin
          addr_d  = reg_addr;
          wdata_d = reg_wdata;
          busy_d  = 1'b1;
        end
        // A PHY turnaround wins; an accepted write waits for the bus to return
        if (ulpi_dir) begin
          state_d = ST_TURN_IN;
        end else if (accept) begin
          state_d = ST_TX_CMD;
        end
      end
      ST_TURN_IN: state_d = ST_RX;
      ST_RX: begin
        if (!ulpi_dir) begin
          state_d     = ST_TURN_OUT;
          rx_end_d    = 1'b1;
          rx_active_d = 1'b0;
        end else if (ulpi_nxt) begin
          rx_data_d    = ulpi_data_in;
          data_valid_d = 1'b1;
          rx_active_d  = 1'b1;
        end else begin
          rx_cmd_d    = rx_cmd_t'(ulpi_data_in);
          rx_active_d = rx_cmd_d.rxevent[0];
`ifdef ULPI_RXCMD_FILTER_EN
          cmd_valid_d = ~cmd_seen_q | (rx_cmd_d != rx_cmd_q);
          cmd_seen_d  = 1'b1;
`else
          cmd_valid_d = 1'b1;
`endif
        end
      end
      ST_TURN_OUT: state_d = busy_q ? ST_TX_CMD : ST_IDLE;
      ST_TX_CMD, ST_TX_DATA: begin
        if (ulpi_dir) begin
          state_d = ST_TURN_IN;
        end else if (ulpi_nxt) begin
          state_d = (state_q == ST_TX_CMD) ? ST_TX_DATA : ST_TX_STP;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TX_STP: begin
        if (ulpi_dir) begin
          state_d = ST_TURN_IN;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    oe_d   = state_d inside {ST_IDLE, ST_TX_CMD, ST_TX_DATA, ST_TX_STP};
    stp_d  = (state_d == ST_TX_STP);
    data_d = '0;
    if (state_d == ST_TX_CMD) begin
      data_d = regwr_cmd(addr_d);
    end else if (state_d == ST_TX_DATA) begin
      data_d = wdata_d;
    end
  end

  always_ff @(posedge clk_ulpi) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      oe_q         <= 1'b0;
      data_q       <= '0;
      stp_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cmd_valid_q  <= 1'b0;
      rx_cmd_q     <= '0;
      data_valid_q <= 1'b0;
      rx_data_q    <= '0;
      rx_active_q  <= 1'b0;
      rx_end_q     <= 1'b0;
`ifdef ULPI_RXCMD_FILTER_EN
      cmd_seen_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      oe_q         <= oe_d;
      data_q       <= data_d;
      stp_q        <= stp_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cmd_valid_q  <= cmd_valid_d;
      rx_cmd_q     <= rx_cmd_d;
      data_valid_q <= data_valid_d;
      rx_data_q    <= rx_data_d;
      rx_active_q  <= rx_active_d;
      rx_end_q     <= rx_end_d;
`ifdef ULPI_RXCMD_FILTER_EN
      cmd_seen_q   <= cmd_seen_d;
`endif
    end
  end

  // Release the pad combinationally the moment the PHY claims it
  assign ulpi_data_oe  = oe_q & ~ulpi_dir;
  assign ulpi_data_out = data_q;
  assign ulpi_stp      = stp_q;
  assign reg_busy      = busy_q;
  assign reg_done      = done_q;
  assign reg_err       = err_q;
  assign rx_cmd_valid  = cmd_valid_q;
  assign rx_cmd        = rx_cmd_q;
  assign rx_data_valid = data_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_active     = rx_active_q;
  assign rx_end        = rx_end_q;

endmodule
